// File: rtl/decode_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : define_state (package)
//  Purpose  : Shared state encoding and load-timeout default for the
//             decode sequencer and its SRAM bus multiplexer.
//  Contents : state_t             - sequencer state enum (3-bit codes)
//             RX_TIMEOUT_DEFAULT  - idle cycles that end a UART file load
//             AUTOSTART_IDLE_CYCLES - idle count that triggers sim autostart
//  Revision : 1.0 - initial release
// ============================================================================
package define_state;

  // One second of UART silence at 50 MHz marks the end of a file load.
  localparam logic [25:0] RX_TIMEOUT_DEFAULT    = 26'd49999999;
  localparam logic [25:0] AUTOSTART_IDLE_CYCLES = 26'd10;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_UART_EN   = 3'd1,
    S_UART_WAIT = 3'd2,
    S_M2        = 3'd3,
    S_M1        = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/decode_sequencer_sram_bus_mux.sv
`default_nettype none
// ============================================================================
//  Module   : sram_bus_mux
//  Purpose  : Selects which requester drives the SRAM controller, based only
//             on the sequencer's registered state. Purely combinational.
//  Ports    : sel_state            - registered sequencer state
//             uart_* / m1_* / m2_* - requester address, write data, we_n
//             vga_addr             - VGA read address (read-only requester)
//             sram_*               - selected address, write data, we_n
//  Revision : 1.0 - initial release
// ============================================================================
module sram_bus_mux
  import define_state::*;
(
  input  state_t      sel_state,
  input  logic [17:0] uart_addr,
  input  logic [15:0] uart_wdata,
  input  logic        uart_we_n,
  input  logic [17:0] m1_addr,
  input  logic [15:0] m1_wdata,
  input  logic        m1_we_n,
  input  logic [17:0] m2_addr,
  input  logic [15:0] m2_wdata,
  input  logic        m2_we_n,
  input  logic [17:0] vga_addr,
  output logic [17:0] sram_address,
  output logic [15:0] sram_write_data,
  output logic        sram_we_n
);

  // Default (idle and any illegal code) is the read-only VGA path, so a
  // requester that does not own the bus can never assert a write.
  always_comb begin
    sram_address    = vga_addr;
    sram_write_data = uart_wdata;
    sram_we_n       = 1'b1;
    case (sel_state)
      S_UART_EN, S_UART_WAIT: begin
        sram_address    = uart_addr;
        sram_write_data = uart_wdata;
        sram_we_n       = uart_we_n;
      end
      S_M2: begin
        sram_address    = m2_addr;
        sram_write_data = m2_wdata;
        sram_we_n       = m2_we_n;
      end
      S_M1: begin
        sram_address    = m1_addr;
        sram_write_data = m1_wdata;
        sram_we_n       = m1_we_n;
      end
      default: begin
        sram_address    = vga_addr;
        sram_write_data = uart_wdata;
        sram_we_n       = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/decode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : decode_sequencer
//  Purpose  : Top-level sequencer: UART file load -> milestone 2 ->
//             milestone 1 -> VGA display, plus SRAM bus ownership.
//  Params   : RX_TIMEOUT    - UART idle cycles that end a file load
//             SIM_AUTOSTART - 1: idle state starts decoding after 10 idle
//                             cycles (simulation shortcut)
//  Ports    : CLOCK_50_I, resetn (async, active-low)
//             uart_rx_line, pb_start          - load triggers
//             uart_* / m1_* / m2_* / vga_addr - SRAM requesters
//             m1_finish, m2_finish            - milestone completion
//             sram_*                          - to SRAM controller
//             uart_init, uart_enable, m1_start, m2_start - one-cycle pulses
//             vga_enable, state_code, decode_done        - status
//  Revision : 1.0 - initial release
// ============================================================================
module decode_sequencer
  import define_state::*;
#(
  parameter logic [25:0] RX_TIMEOUT    = RX_TIMEOUT_DEFAULT,
  parameter bit          SIM_AUTOSTART = 1'b0
) (
  input  logic        CLOCK_50_I,
  input  logic        resetn,
  input  logic        uart_rx_line,
  input  logic        pb_start,
  input  logic [17:0] uart_addr,
  input  logic [15:0] uart_wdata,
  input  logic        uart_we_n,
  input  logic [17:0] m1_addr,
  input  logic [15:0] m1_wdata,
  input  logic        m1_we_n,
  input  logic        m1_finish,
  input  logic [17:0] m2_addr,
  input  logic [15:0] m2_wdata,
  input  logic        m2_we_n,
  input  logic        m2_finish,
  input  logic [17:0] vga_addr,
  output logic [17:0] sram_address,
  output logic [15:0] sram_write_data,
  output logic        sram_we_n,
  output logic        uart_init,
  output logic        uart_enable,
  output logic        m1_start,
  output logic        m2_start,
  output logic        vga_enable,
  output logic [2:0]  state_code,
  output logic        decode_done
);

  state_t      r_state;
  state_t      w_state_next;
  logic [25:0] r_rx_timer;
  logic        r_uart_init, r_uart_enable, r_m1_start, r_m2_start;
  logic        r_vga_enable, r_decode_done;
  logic        w_uart_init, w_uart_enable, w_m1_start, w_m2_start;
  logic        w_vga_enable, w_decode_done;
  logic        w_rx_activity;
  logic        w_autostart;

  assign w_rx_activity = !uart_rx_line || pb_start;
  assign w_autostart   = SIM_AUTOSTART && (r_rx_timer == AUTOSTART_IDLE_CYCLES);

  // Idle counter: restarts on every UART write and on each uart_init pulse,
  // saturates so a long idle period never wraps back onto RX_TIMEOUT.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      r_rx_timer <= '0;
    end else if (r_uart_init || !uart_we_n) begin
      r_rx_timer <= '0;
    end else if (r_rx_timer != '1) begin
      r_rx_timer <= r_rx_timer + 26'd1;
    end
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_uart_init   <= 1'b0;
      r_uart_enable <= 1'b0;
      r_m1_start    <= 1'b0;
      r_m2_start    <= 1'b0;
      r_vga_enable  <= 1'b1;
      r_decode_done <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_uart_init   <= w_uart_init;
      r_uart_enable <= w_uart_enable;
      r_m1_start    <= w_m1_start;
      r_m2_start    <= w_m2_start;
      r_vga_enable  <= w_vga_enable;
      r_decode_done <= w_decode_done;
    end
  end

  // Start pulses land in the first cycle of their target state, so a finish
  // is only accepted once the matching start register has dropped.
  always_comb begin
    w_state_next  = r_state;
    w_uart_init   = 1'b0;
    w_uart_enable = 1'b0;
    w_m1_start    = 1'b0;
    w_m2_start    = 1'b0;
    w_vga_enable  = r_vga_enable;
    w_decode_done = r_decode_done;
    case (r_state)
      S_IDLE: begin
        if (w_rx_activity) begin
          w_uart_init   = 1'b1;
          w_vga_enable  = 1'b0;
          w_decode_done = 1'b0;
          w_state_next  = S_UART_EN;
        end else if (w_autostart) begin
          w_m2_start    = 1'b1;
          w_vga_enable  = 1'b0;
          w_decode_done = 1'b0;
          w_state_next  = S_M2;
        end
      end
      S_UART_EN: begin
        w_uart_enable = 1'b1;
        w_state_next  = S_UART_WAIT;
      end
      S_UART_WAIT: begin
        // An empty load (nothing written past address 0) keeps waiting.
        if ((r_rx_timer == RX_TIMEOUT) && (uart_addr != '0)) begin
          w_uart_init  = 1'b1;
          w_m2_start   = 1'b1;
          w_state_next = S_M2;
        end
      end
      S_M2: begin
        if (m2_finish && !r_m2_start) begin
          w_m1_start   = 1'b1;
          w_state_next = S_M1;
        end
      end
      S_M1: begin
        if (m1_finish && !r_m1_start) begin
          w_vga_enable  = 1'b1;
          w_decode_done = 1'b1;
          w_state_next  = S_IDLE;
        end
      end
      default: begin
        w_vga_enable = 1'b1;
        w_state_next = S_IDLE;
      end
    endcase
  end

  sram_bus_mux u_sram_bus_mux (
    .sel_state       (r_state),
    .uart_addr       (uart_addr),
    .uart_wdata      (uart_wdata),
    .uart_we_n       (uart_we_n),
    .m1_addr         (m1_addr),
    .m1_wdata        (m1_wdata),
    .m1_we_n         (m1_we_n),
    .m2_addr         (m2_addr),
    .m2_wdata        (m2_wdata),
    .m2_we_n         (m2_we_n),
    .vga_addr        (vga_addr),
    .sram_address    (sram_address),
    .sram_write_data (sram_write_data),
    .sram_we_n       (sram_we_n)
  );

  assign uart_init   = r_uart_init;
  assign uart_enable = r_uart_enable;
  assign m1_start    = r_m1_start;
  assign m2_start    = r_m2_start;
  assign vga_enable  = r_vga_enable;
  assign decode_done = r_decode_done;
  assign state_code  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_decode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_sequencer
//  Purpose  : Directed self-checking bench for decode_sequencer
//             (RX_TIMEOUT = 100, SIM_AUTOSTART = 0).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decode_sequencer;

  logic        CLOCK_50_I = 1'b0;
  logic        resetn     = 1'b0;
  logic        uart_rx_line = 1'b1;
  logic        pb_start   = 1'b0;
  logic [17:0] uart_addr  = '0;
  logic [15:0] uart_wdata = '0;
  logic        uart_we_n  = 1'b1;
  logic [17:0] m1_addr    = 18'h11111;
  logic [15:0] m1_wdata   = 16'h1111;
  logic        m1_we_n    = 1'b1;
  logic        m1_finish  = 1'b0;
  logic [17:0] m2_addr    = 18'h22222;
  logic [15:0] m2_wdata   = 16'h2222;
  logic        m2_we_n    = 1'b1;
  logic        m2_finish  = 1'b0;
  logic [17:0] vga_addr   = 18'h12345;
  logic [17:0] sram_address;
  logic [15:0] sram_write_data;
  logic        sram_we_n;
  logic        uart_init, uart_enable, m1_start, m2_start, vga_enable, decode_done;
  logic [2:0]  state_code;

  int checks = 0;
  int errors = 0;
  logic seen_start;

  always #10 CLOCK_50_I = ~CLOCK_50_I;

  decode_sequencer #(
    .RX_TIMEOUT    (26'd100),
    .SIM_AUTOSTART (1'b0)
  ) dut (
    .CLOCK_50_I      (CLOCK_50_I),
    .resetn          (resetn),
    .uart_rx_line    (uart_rx_line),
    .pb_start        (pb_start),
    .uart_addr       (uart_addr),
    .uart_wdata      (uart_wdata),
    .uart_we_n       (uart_we_n),
    .m1_addr         (m1_addr),
    .m1_wdata        (m1_wdata),
    .m1_we_n         (m1_we_n),
    .m1_finish       (m1_finish),
    .m2_addr         (m2_addr),
    .m2_wdata        (m2_wdata),
    .m2_we_n         (m2_we_n),
    .m2_finish       (m2_finish),
    .vga_addr        (vga_addr),
    .sram_address    (sram_address),
    .sram_write_data (sram_write_data),
    .sram_we_n       (sram_we_n),
    .uart_init       (uart_init),
    .uart_enable     (uart_enable),
    .m1_start        (m1_start),
    .m2_start        (m2_start),
    .vga_enable      (vga_enable),
    .state_code      (state_code),
    .decode_done     (decode_done)
  );

  task automatic tick();
    @(posedge CLOCK_50_I);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // ---------------- reset state ----------------
    tick(); tick();
    #1;
    check("rst_state",     32'(state_code), 32'd0);
    check("rst_vga_en",    32'(vga_enable), 32'd1);
    check("rst_done",      32'(decode_done), 32'd0);
    check("rst_init",      32'(uart_init), 32'd0);
    check("rst_m2_start",  32'(m2_start), 32'd0);
    check("rst_we_n",      32'(sram_we_n), 32'd1);
    check("rst_addr",      32'(sram_address), 32'h12345);
    @(posedge CLOCK_50_I); #1;
    resetn = 1'b1;
    tick();

    // ---------------- pb_start launches a load ----------------
    pb_start = 1'b1;
    tick();
    pb_start = 1'b0;
    check("c1_uart_init",  32'(uart_init), 32'd1);
    check("c1_state",      32'(state_code), 32'd1);
    check("c1_vga_en",     32'(vga_enable), 32'd0);
    tick();
    check("c2_uart_en",    32'(uart_enable), 32'd1);
    check("c2_uart_init",  32'(uart_init), 32'd0);
    check("c2_state",      32'(state_code), 32'd2);
    uart_addr = 18'h00abc;
    #1;
    check("uart_addr_mux", 32'(sram_address), 32'h00abc);

    // ---------------- timeout with empty load is ignored ----------------
    uart_addr = 18'h0;
    seen_start = 1'b0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (m2_start) seen_start = 1'b1;
    end
    check("empty_no_m2_start", 32'(seen_start), 32'd0);
    check("empty_state",       32'(state_code), 32'd2);

    // ---------------- UART writes 0..5 then idle ----------------
    for (int a = 0; a < 6; a++) begin
      uart_addr  = 18'(a);
      uart_wdata = 16'(16'hA000 + a);
      uart_we_n  = 1'b0;
      #1;
      if (a == 2) begin
        check("uart_wr_we_n",  32'(sram_we_n), 32'd0);
        check("uart_wr_data",  32'(sram_write_data), 32'hA002);
      end
      tick();
    end
    uart_we_n = 1'b1;
    for (int k = 0; k < 100; k++) tick();
    check("to_100_m2_start", 32'(m2_start), 32'd0);
    check("to_100_state",    32'(state_code), 32'd2);
    // Same-cycle finish alongside the start must be ignored.
    tick();
    check("to_101_m2_start", 32'(m2_start), 32'd1);
    check("to_101_state",    32'(state_code), 32'd3);
    check("to_101_init",     32'(uart_init), 32'd1);
    m2_finish = 1'b1;
    tick();
    m2_finish = 1'b0;
    check("m2_samecyc_state", 32'(state_code), 32'd3);
    check("m2_start_width",   32'(m2_start), 32'd0);
    check("m2_samecyc_m1st",  32'(m1_start), 32'd0);

    // ---------------- S_M2 ignores m1_finish; we_n follows m2 only ----------
    m1_finish = 1'b1;
    m1_we_n   = 1'b0;
    m2_we_n   = 1'b0;
    #1;
    check("m2_we_n_low",  32'(sram_we_n), 32'd0);
    check("m2_addr_mux",  32'(sram_address), 32'h22222);
    tick();
    check("m2_ign_m1fin", 32'(state_code), 32'd3);
    check("m2_ign_m1st",  32'(m1_start), 32'd0);
    m2_we_n = 1'b1;
    #1;
    check("m2_we_n_owner", 32'(sram_we_n), 32'd1);
    m1_finish = 1'b0;

    m2_finish = 1'b1;
    tick();
    m2_finish = 1'b0;
    check("m1_start_pulse", 32'(m1_start), 32'd1);
    check("m1_state",       32'(state_code), 32'd4);
    check("m1_addr_mux",    32'(sram_address), 32'h11111);
    m1_finish = 1'b1;       // coincides with the m1_start cycle: ignored
    tick();
    check("m1_samecyc_state", 32'(state_code), 32'd4);
    check("m1_start_width",   32'(m1_start), 32'd0);
    tick();                 // now honoured
    m1_finish = 1'b0;
    check("done_state",    32'(state_code), 32'd0);
    check("done_vga_en",   32'(vga_enable), 32'd1);
    check("done_flag",     32'(decode_done), 32'd1);
    check("done_addr",     32'(sram_address), 32'h12345);
    check("done_we_n",     32'(sram_we_n), 32'd1);

    // ---------------- next load clears decode_done ----------------
    pb_start = 1'b1;
    tick();
    pb_start = 1'b0;
    check("reload_init", 32'(uart_init), 32'd1);
    check("reload_done", 32'(decode_done), 32'd0);
    tick();
    uart_addr = 18'd3;
    uart_we_n = 1'b0;
    tick();
    uart_we_n = 1'b1;
    for (int k = 0; k < 101; k++) tick();
    check("reload_m2_state", 32'(state_code), 32'd3);
    tick();
    m2_finish = 1'b1;
    tick();
    m2_finish = 1'b0;
    check("reload_m1_state", 32'(state_code), 32'd4);
    check("reload_m1_we_n",  32'(sram_we_n), 32'd0);

    // ---------------- reset mid-decode aborts asynchronously ----------------
    #4;
    resetn = 1'b0;
    #1;
    check("arst_state",   32'(state_code), 32'd0);
    check("arst_we_n",    32'(sram_we_n), 32'd1);
    check("arst_addr",    32'(sram_address), 32'h12345);
    check("arst_vga_en",  32'(vga_enable), 32'd1);
    @(posedge CLOCK_50_I); #1;
    resetn = 1'b1;
    seen_start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (m1_start || m2_start) seen_start = 1'b1;
    end
    check("arst_no_restart", 32'(seen_start), 32'd0);
    check("arst_idle",       32'(state_code), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
